dm_access_arbiter: RTL and testbench

// - Shares the single-port data memory between the CPU M stage (port C) and the debug/program loader (port D).
// - Port C has fixed priority. Port D is served in idle cycles.
// - A starvation counter forces a one-cycle CPU stall so that port D always makes progress.
// - Drives the DM write strobe, address, data and store select. Returns read data to port D with a registered response.

---
 rtl/dm_pkg.sv | 19 +
 rtl/dm_access_arbiter.sv | 125 ++++++++++++
 tb/tb_dm_access_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access arbiter.
// Holds the store-select encodings and the grant encoding used by the
// arbiter's mux.
package dm_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    // Store select encodings presented to the data memory
    localparam logic [1:0] SS_WORD = 2'b11;
    localparam logic [1:0] SS_HALF = 2'b01;
    localparam logic [1:0] SS_BYTE = 2'b10;

    // Grant encoding for the DM port mux
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_C    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

endpackage

// File: rtl/dm_access_arbiter.sv
// dm_access_arbiter
// Shares the single-port data memory between the CPU M stage (port C, fixed
// priority) and the debug/program loader (port D, served in idle cycles).
// A saturating starvation counter forces D ahead of C for one cycle after
// STARVE_MAX consecutive blocked cycles, stalling the CPU for that cycle.
// Ports:
//   clk, reset                      clock, async active-high reset
//   cpu_req/we/exc/addr/wdata/storesel   CPU M-stage access
//   cpu_stall                       comb: CPU must hold M stage this cycle
//   dbg_valid/we/addr/wdata         port D request (held until accepted)
//   dbg_ready                       comb: port D accepted this cycle
//   dbg_rvalid, dbg_rdata           registered read response for port D
//   dm_rdata                        comb read data from DM at dm_addr
//   dm_addr/wdata/storesel/we       DM access of the granted port
module dm_access_arbiter
    import dm_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned CNT_W      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic        cpu_exc,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_storesel,
    output logic        cpu_stall,
    input  logic        dbg_valid,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ready,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    input  logic [31:0] dm_rdata,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [1:0]  dm_storesel,
    output logic        dm_we
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              dbg_rvalid_q, dbg_rvalid_d;
    logic [DATA_W-1:0] dbg_rdata_q,  dbg_rdata_d;

    logic       force_d;
    logic [1:0] gnt;

    // Word alignment drops the low address bits of port D
    logic unused_dbg_addr_lsb;
    assign unused_dbg_addr_lsb = ^dbg_addr[1:0];

    // Grant selection: forced D beats C, C beats D, D takes idle cycles
    always_comb begin
        force_d = dbg_valid && (starve_cnt_q == CNT_MAX);
        gnt     = GNT_NONE;
        if (force_d) begin
            gnt = GNT_D;
        end else if (cpu_req) begin
            gnt = GNT_C;
        end else if (dbg_valid) begin
            gnt = GNT_D;
        end
    end

    // DM port mux; an idle cycle presents the CPU address with no write
    always_comb begin
        cpu_stall   = force_d && cpu_req;
        dbg_ready   = 1'b0;
        dm_we       = 1'b0;
        dm_addr     = cpu_addr;
        dm_wdata    = cpu_wdata;
        dm_storesel = cpu_storesel;
        case (gnt)
            GNT_C: begin
                // An excepting store keeps the grant but must not commit
                dm_we = cpu_we && !cpu_exc;
            end
            GNT_D: begin
                dbg_ready   = 1'b1;
                dm_we       = dbg_we;
                dm_addr     = {dbg_addr[31:2], 2'b00};
                dm_wdata    = dbg_wdata;
                dm_storesel = SS_WORD;
            end
            default: ;
        endcase
    end

    // Starvation counter and read-response next state
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (dbg_ready) begin
            starve_cnt_d = '0;
        end else if (dbg_valid && (starve_cnt_q != CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end

        dbg_rvalid_d = dbg_ready && !dbg_we;
        dbg_rdata_d  = dbg_rdata_q;
        if (dbg_rvalid_d) begin
            dbg_rdata_d = dm_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Directed bench for dm_access_arbiter with a small word-addressed DM model.
// A second instance with STARVE_MAX = 1 covers the every-other-cycle case.
module tb_dm_access_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_exc;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [1:0]  cpu_storesel;
    logic        cpu_stall;
    logic        dbg_valid, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        dbg_ready, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic [31:0] dm_rdata, dm_addr, dm_wdata;
    logic [1:0]  dm_storesel;
    logic        dm_we;

    logic        s1_stall, s1_ready, s1_rvalid, s1_we;
    logic [31:0] s1_rdata, s1_addr, s1_wdata;
    logic [1:0]  s1_storesel;
    logic [31:0] s1_dm_rdata = 32'h0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] mem [64];

    always #5 clk = ~clk;

    dm_access_arbiter #(.STARVE_MAX(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_exc(cpu_exc),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_storesel(cpu_storesel),
        .cpu_stall(cpu_stall),
        .dbg_valid(dbg_valid), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ready(dbg_ready),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .dm_rdata(dm_rdata), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_storesel(dm_storesel), .dm_we(dm_we)
    );

    dm_access_arbiter #(.STARVE_MAX(1), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_exc(cpu_exc),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_storesel(cpu_storesel),
        .cpu_stall(s1_stall),
        .dbg_valid(dbg_valid), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ready(s1_ready),
        .dbg_rvalid(s1_rvalid), .dbg_rdata(s1_rdata),
        .dm_rdata(s1_dm_rdata), .dm_addr(s1_addr), .dm_wdata(s1_wdata),
        .dm_storesel(s1_storesel), .dm_we(s1_we)
    );

    // DM model: combinational read, byte-lane writes at the clock edge
    assign dm_rdata = mem[dm_addr[7:2]];

    always @(posedge clk) begin
        if (dm_we) begin
            case (dm_storesel)
                2'b11: mem[dm_addr[7:2]] <= dm_wdata;
                2'b01: mem[dm_addr[7:2]][16*int'(dm_addr[1]) +: 16] <= dm_wdata[15:0];
                2'b10: mem[dm_addr[7:2]][8*int'(dm_addr[1:0]) +: 8] <= dm_wdata[7:0];
                default: ;
            endcase
        end
    end

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_exc = 1'b0;
        cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_storesel = 2'b11;
        dbg_valid = 1'b0; dbg_we = 1'b0; dbg_addr = 32'h0; dbg_wdata = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        cpu_addr = 32'h0000_0044;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (dbg_rvalid !== 1'b0) $display("FAIL rst_rvalid: got %0h want 0", dbg_rvalid); else pass_cnt++;
        total_cnt++; if (dbg_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 00000000", dbg_rdata); else pass_cnt++;
        total_cnt++; if (dut.starve_cnt_q !== 8'd0) $display("FAIL rst_cnt: got %0d want 0", dut.starve_cnt_q); else pass_cnt++;
        total_cnt++; if ({cpu_stall, dbg_ready, dm_we} !== 3'b000) $display("FAIL rst_idle_ctl: got %b want 000", {cpu_stall, dbg_ready, dm_we}); else pass_cnt++;
        total_cnt++; if (dm_addr !== 32'h0000_0044) $display("FAIL idle_addr: got %h want 00000044", dm_addr); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_dbg_write();
        @(negedge clk);
        dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h10; dbg_wdata = 32'hCAFE_F00D;
        #1;
        total_cnt++; if ({dbg_ready, dm_we, cpu_stall} !== 3'b110) $display("FAIL dwr_ctl: got %b want 110", {dbg_ready, dm_we, cpu_stall}); else pass_cnt++;
        total_cnt++; if (dm_addr !== 32'h10) $display("FAIL dwr_addr: got %h want 00000010", dm_addr); else pass_cnt++;
        total_cnt++; if (dm_storesel !== 2'b11) $display("FAIL dwr_ss: got %b want 11", dm_storesel); else pass_cnt++;
        total_cnt++; if (dm_wdata !== 32'hCAFE_F00D) $display("FAIL dwr_wdata: got %h want cafef00d", dm_wdata); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (dbg_rvalid !== 1'b0) $display("FAIL dwr_norvalid: got %0h want 0", dbg_rvalid); else pass_cnt++;
        @(negedge clk);
        dbg_valid = 1'b0; dbg_we = 1'b0;
    endtask

    task automatic test_dbg_read();
        @(negedge clk);
        dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
        #1;
        total_cnt++; if ({dbg_ready, dm_we} !== 2'b10) $display("FAIL drd_ctl: got %b want 10", {dbg_ready, dm_we}); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (dbg_rvalid !== 1'b1) $display("FAIL drd_rvalid: got %0h want 1", dbg_rvalid); else pass_cnt++;
        total_cnt++; if (dbg_rdata !== 32'hCAFE_F00D) $display("FAIL drd_rdata: got %h want cafef00d", dbg_rdata); else pass_cnt++;
        @(negedge clk);
        dbg_valid = 1'b0;
        @(posedge clk); #1;
        total_cnt++; if (dbg_rvalid !== 1'b0) $display("FAIL drd_pulse: got %0h want 0", dbg_rvalid); else pass_cnt++;
        total_cnt++; if (dbg_rdata !== 32'hCAFE_F00D) $display("FAIL drd_hold: got %h want cafef00d", dbg_rdata); else pass_cnt++;
    endtask

    task automatic test_addr_align();
        @(negedge clk);
        dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h13;
        #1;
        total_cnt++; if (dm_addr !== 32'h10) $display("FAIL align_addr: got %h want 00000010", dm_addr); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (dbg_rdata !== 32'hCAFE_F00D) $display("FAIL align_rdata: got %h want cafef00d", dbg_rdata); else pass_cnt++;
        @(negedge clk);
        dbg_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'h1234_5678;
        @(negedge clk);
        dbg_we = 1'b0; dbg_addr = 32'h10;
        @(posedge clk); #1;
        total_cnt++; if ({dbg_rvalid, dbg_rdata} !== {1'b1, 32'hCAFE_F00D}) $display("FAIL b2b_first: got %0h/%h want 1/cafef00d", dbg_rvalid, dbg_rdata); else pass_cnt++;
        @(negedge clk);
        dbg_addr = 32'h20;
        @(posedge clk); #1;
        total_cnt++; if ({dbg_rvalid, dbg_rdata} !== {1'b1, 32'h1234_5678}) $display("FAIL b2b_second: got %0h/%h want 1/12345678", dbg_rvalid, dbg_rdata); else pass_cnt++;
        @(negedge clk);
        dbg_valid = 1'b0;
        @(posedge clk); #1;
        total_cnt++; if (dbg_rvalid !== 1'b0) $display("FAIL b2b_end: got %0h want 0", dbg_rvalid); else pass_cnt++;
    endtask

    task automatic test_cpu_exc();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_exc = 1'b1;
        cpu_addr = 32'h7; cpu_wdata = 32'h55; cpu_storesel = 2'b10;
        dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h4;
        #1;
        total_cnt++; if ({dm_we, cpu_stall, dbg_ready} !== 3'b000) $display("FAIL exc_ctl: got %b want 000", {dm_we, cpu_stall, dbg_ready}); else pass_cnt++;
        total_cnt++; if (dm_addr !== 32'h7) $display("FAIL exc_addr: got %h want 00000007", dm_addr); else pass_cnt++;
        @(negedge clk);
        cpu_exc = 1'b0;
        #1;
        total_cnt++; if ({dm_we, cpu_stall, dbg_ready} !== 3'b100) $display("FAIL st_ctl: got %b want 100", {dm_we, cpu_stall, dbg_ready}); else pass_cnt++;
        total_cnt++; if ({dm_addr, dm_storesel, dm_wdata} !== {32'h7, 2'b10, 32'h55}) $display("FAIL st_bus: got %h/%b/%h want 00000007/10/00000055", dm_addr, dm_storesel, dm_wdata); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (dut.starve_cnt_q !== 8'd2) $display("FAIL exc_cnt: got %0d want 2", dut.starve_cnt_q); else pass_cnt++;
        cpu_req = 1'b0; cpu_we = 1'b0;
        // D now gets the idle cycle and reads back the stored byte
        #1;
        total_cnt++; if (dbg_ready !== 1'b1) $display("FAIL byte_rd_ready: got %0h want 1", dbg_ready); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (dbg_rdata !== 32'h5500_0000) $display("FAIL byte_rd_data: got %h want 55000000", dbg_rdata); else pass_cnt++;
        total_cnt++; if (dut.starve_cnt_q !== 8'd0) $display("FAIL byte_rd_cnt: got %0d want 0", dut.starve_cnt_q); else pass_cnt++;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_hold();
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 32'h100;
        dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
        repeat (3) @(negedge clk);
        dbg_valid = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++; if (dut.starve_cnt_q !== 8'd3) $display("FAIL hold_cnt: got %0d want 3", dut.starve_cnt_q); else pass_cnt++;
        dbg_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            total_cnt++; if (dbg_ready !== (i == 5)) $display("FAIL hold_ready[%0d]: got %0h want %0h", i, dbg_ready, (i == 5)); else pass_cnt++;
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_starve();
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 32'h100;
        dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
        for (int i = 0; i < 18; i++) begin
            #1;
            total_cnt++; if ({dbg_ready, cpu_stall} !== {2{i % 9 == 8}}) $display("FAIL starve[%0d]: got rdy/stall %b want %b", i, {dbg_ready, cpu_stall}, {2{i % 9 == 8}}); else pass_cnt++;
            if (i % 9 == 8) begin
                total_cnt++; if (dm_addr !== 32'h10) $display("FAIL starve_addr[%0d]: got %h want 00000010", i, dm_addr); else pass_cnt++;
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        cpu_req = 1'b1; dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
        repeat (5) @(negedge clk);
        total_cnt++; if (dut.starve_cnt_q !== 8'd5) $display("FAIL mid_cnt5: got %0d want 5", dut.starve_cnt_q); else pass_cnt++;
        #2 reset = 1'b1;
        #1;
        total_cnt++; if (dut.starve_cnt_q !== 8'd0) $display("FAIL mid_cnt_rst: got %0d want 0", dut.starve_cnt_q); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0; cpu_req = 1'b0;
        @(posedge clk); #1;
        total_cnt++; if ({dbg_rvalid, dbg_rdata} !== {1'b1, 32'hCAFE_F00D}) $display("FAIL mid_pending: got %0h/%h want 1/cafef00d", dbg_rvalid, dbg_rdata); else pass_cnt++;
        #1 reset = 1'b1;
        #1;
        total_cnt++; if ({dbg_rvalid, dbg_rdata} !== 33'h0) $display("FAIL mid_rsp_rst: got %0h/%h want 0/00000000", dbg_rvalid, dbg_rdata); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0; cpu_req = 1'b1; dbg_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            total_cnt++; if (dbg_ready !== (i == 8)) $display("FAIL restart[%0d]: got %0h want %0h", i, dbg_ready, (i == 8)); else pass_cnt++;
            total_cnt++; if ({s1_ready, s1_stall} !== {2{i % 2 == 1}}) $display("FAIL max1[%0d]: got rdy/stall %b want %b", i, {s1_ready, s1_stall}, {2{i % 2 == 1}}); else pass_cnt++;
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        test_reset();
        test_dbg_write();
        test_dbg_read();
        test_addr_align();
        test_back_to_back();
        test_cpu_exc();
        test_hold();
        test_starve();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
